bsg_gateway_chip_io_link_bringup: RTL and testbench

BSG_GATEWAY_CHIP_IO_LINK_BRINGUP -- requirements
Module: bsg_gateway_chip_io_link_bringup

---
 rtl/bsg_chip_pkg.sv | 63 ++++++
 rtl/bsg_gateway_chip_io_link_bringup_if.sv | 16 +
 rtl/bsg_tag_packet_serializer.sv | 74 +++++++
 rtl/bsg_gateway_chip_io_link_bringup.sv | 130 +++++++++++++
 tb/tb_bsg_gateway_chip_io_link_bringup.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/bsg_chip_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bsg_chip_pkg                                                               |
// | Shared tag payload types, bring-up step table and FSM state encodings.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package bsg_chip_pkg;

   typedef struct packed {
      logic up_link_reset;
      logic down_link_reset;
      logic async_token_reset;
   } bsg_chip_io_tag_payload_s;

   typedef struct packed {
      logic up_link_reset;
      logic down_link_reset;
   } bsg_chip_core_tag_payload_s;

   typedef struct packed {
      logic       is_core;
      logic       dnr;
      logic [2:0] payload;
   } bsg_chip_step_s;

   localparam int c_io_payload_w   = 3;
   localparam int c_core_payload_w = 2;

   localparam logic [3:0] c_last_pkt_step = 4'd7;
   localparam logic [3:0] c_final_step    = 4'd8;

   localparam bsg_chip_io_tag_payload_s   c_io_all_reset     = 3'b111;
   localparam bsg_chip_io_tag_payload_s   c_io_up_down_reset = 3'b110;
   localparam bsg_chip_io_tag_payload_s   c_io_down_reset    = 3'b010;
   localparam bsg_chip_io_tag_payload_s   c_io_no_reset      = 3'b000;
   localparam bsg_chip_core_tag_payload_s c_core_all_reset   = 2'b11;
   localparam bsg_chip_core_tag_payload_s c_core_no_reset    = 2'b00;

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_send = 2'd1;
   localparam logic [1:0] c_st_gap  = 2'd2;
   localparam logic [1:0] c_st_done = 2'd3;

   // Core payloads sit in the low two bits of the shared 3-bit payload field.
   function automatic bsg_chip_step_s bsg_chip_step_entry(input logic [3:0] idx);
      bsg_chip_step_s e;
      e = '0;
      case (idx)
         4'd0: e = '{is_core: 1'b0, dnr: 1'b0, payload: c_io_all_reset};
         4'd1: e = '{is_core: 1'b1, dnr: 1'b0, payload: {1'b0, c_core_all_reset}};
         4'd2: e = '{is_core: 1'b0, dnr: 1'b1, payload: c_io_all_reset};
         4'd3: e = '{is_core: 1'b1, dnr: 1'b1, payload: {1'b0, c_core_all_reset}};
         4'd4: e = '{is_core: 1'b0, dnr: 1'b1, payload: c_io_up_down_reset};
         4'd5: e = '{is_core: 1'b0, dnr: 1'b1, payload: c_io_down_reset};
         4'd6: e = '{is_core: 1'b0, dnr: 1'b1, payload: c_io_no_reset};
         4'd7: e = '{is_core: 1'b1, dnr: 1'b1, payload: {1'b0, c_core_no_reset}};
         default: e = '0;
      endcase
      return e;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_gateway_chip_io_link_bringup_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bsg_gateway_chip_io_link_bringup_if                                        |
// | Start request and tag stream / status bundle of the bring-up block.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface bsg_gateway_chip_io_link_bringup_if;
   logic start_i;
   logic tag_data_o;
   logic busy_o;
   logic done_o;

   modport master (output start_i, input tag_data_o, input busy_o, input done_o);
   modport slave  (input start_i, output tag_data_o, output busy_o, output done_o);
endinterface
`default_nettype wire

// File: rtl/bsg_tag_packet_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bsg_tag_packet_serializer                                                  |
// | Turns one tag packet (id, dnr, length, payload) into a registered bit stream.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bsg_tag_packet_serializer #(
   parameter int lg_els_p   = 4,
   parameter int lg_width_p = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  v_i,
   input  logic [lg_els_p-1:0]   node_id_i,
   input  logic                  dnr_i,
   input  logic [lg_width_p-1:0] len_i,
   input  logic [2:0]            payload_i,
   output logic                  ready_o,
   output logic                  last_o,
   output logic                  data_o
);

   localparam int c_shift_w = lg_els_p + 1 + lg_width_p + 3;
   localparam int c_cnt_w   = $clog2(c_shift_w + 2);
   localparam int c_hdr_len = lg_els_p + 1 + lg_width_p;

   logic [c_shift_w-1:0] shift_q, shift_d;
   logic [c_cnt_w-1:0]   bits_left_q, bits_left_d;
   logic                 active_q, active_d;
   logic                 data_q, data_d;
   logic                 w_accept;

   assign ready_o  = !active_q || (bits_left_q == '0);
   assign last_o   = active_q && (bits_left_q == '0);
   assign data_o   = data_q;
   assign w_accept = v_i && ready_o;

   // The start bit goes out on the accepting edge; the shift register holds the
   // remaining fields, payload pre-reversed so everything shifts out MSB first.
   always_comb begin
      shift_d     = shift_q;
      bits_left_d = bits_left_q;
      active_d    = active_q;
      data_d      = 1'b0;
      if (w_accept) begin
         active_d    = 1'b1;
         data_d      = 1'b1;
         shift_d     = {node_id_i, dnr_i, len_i, payload_i[0], payload_i[1], payload_i[2]};
         bits_left_d = c_cnt_w'(c_hdr_len) + c_cnt_w'(len_i);
      end else if (active_q && (bits_left_q != '0)) begin
         data_d      = shift_q[c_shift_w-1];
         shift_d     = {shift_q[c_shift_w-2:0], 1'b0};
         bits_left_d = bits_left_q - c_cnt_w'(1);
      end else begin
         active_d    = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         shift_q     <= '0;
         bits_left_q <= '0;
         active_q    <= 1'b0;
         data_q      <= 1'b0;
      end else begin
         shift_q     <= shift_d;
         bits_left_q <= bits_left_d;
         active_q    <= active_d;
         data_q      <= data_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/bsg_gateway_chip_io_link_bringup.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bsg_gateway_chip_io_link_bringup                                           |
// | Sequences the io/core tag packets that take the chip io link out of reset. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bsg_gateway_chip_io_link_bringup
   import bsg_chip_pkg::*;
#(
   parameter int lg_els_p       = 4,
   parameter int lg_width_p     = 4,
   parameter int io_node_id_p   = 0,
   parameter int core_node_id_p = 1,
   parameter int gap_cycles_p   = 64
) (
   input  logic clk_i,
   input  logic reset_n_i,
   bsg_gateway_chip_io_link_bringup_if.slave link_if
);

   localparam int                    c_gap_w    = $clog2(gap_cycles_p + 1);
   localparam logic [c_gap_w-1:0]    c_gap_last = c_gap_w'(gap_cycles_p - 1);
   localparam logic [lg_els_p-1:0]   c_io_id    = lg_els_p'(io_node_id_p);
   localparam logic [lg_els_p-1:0]   c_core_id  = lg_els_p'(core_node_id_p);
   localparam logic [lg_width_p-1:0] c_io_len   = lg_width_p'(c_io_payload_w);
   localparam logic [lg_width_p-1:0] c_core_len = lg_width_p'(c_core_payload_w);

   logic               rst_meta_q, rst_sync_q;
   logic               w_rst_n;
   logic [1:0]         state_q, state_d;
   logic [3:0]         step_q, step_d;
   logic [c_gap_w-1:0] gap_cnt_q, gap_cnt_d;
   logic               w_gap_end;
   logic               w_ser_v, w_ser_ready, w_ser_last;
   logic [3:0]         w_step_idx;
   bsg_chip_step_s     w_entry;

   // Assertion is immediate, release waits two clock edges.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rst_meta_q <= 1'b0;
         rst_sync_q <= 1'b0;
      end else begin
         rst_meta_q <= 1'b1;
         rst_sync_q <= rst_meta_q;
      end
   end
   assign w_rst_n = rst_sync_q;

   always_ff @(posedge clk_i or negedge w_rst_n) begin
      if (!w_rst_n) begin
         state_q   <= c_st_idle;
         step_q    <= '0;
         gap_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         gap_cnt_q <= gap_cnt_d;
      end
   end

   assign w_gap_end = (gap_cnt_q == c_gap_last);

   // step_q advances when a packet ends, so during GAP it names the next step.
   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      gap_cnt_d = gap_cnt_q;
      case (state_q)
         c_st_idle, c_st_done: begin
            if (w_ser_v) begin
               state_d   = c_st_send;
               step_d    = '0;
               gap_cnt_d = '0;
            end
         end
         c_st_send: begin
            if (w_ser_last) begin
               state_d   = c_st_gap;
               step_d    = step_q + 4'd1;
               gap_cnt_d = '0;
            end
         end
         c_st_gap: begin
            if (w_gap_end) begin
               gap_cnt_d = '0;
               state_d   = (step_q == c_final_step) ? c_st_done : c_st_send;
            end else begin
               gap_cnt_d = gap_cnt_q + c_gap_w'(1);
            end
         end
         default: state_d = c_st_idle;
      endcase
   end

   always_comb begin
      w_ser_v    = 1'b0;
      w_step_idx = step_q;
      case (state_q)
         c_st_idle, c_st_done: begin
            w_ser_v    = link_if.start_i && w_ser_ready;
            w_step_idx = '0;
         end
         c_st_gap: w_ser_v = w_gap_end && (step_q <= c_last_pkt_step) && w_ser_ready;
         default:  w_ser_v = 1'b0;
      endcase
   end

   assign w_entry        = bsg_chip_step_entry(w_step_idx);
   assign link_if.busy_o = (state_q == c_st_send) || (state_q == c_st_gap);
   assign link_if.done_o = (state_q == c_st_done);

   bsg_tag_packet_serializer #(
      .lg_els_p   (lg_els_p),
      .lg_width_p (lg_width_p)
   ) u_serializer (
      .clk_i     (clk_i),
      .rst_n_i   (w_rst_n),
      .v_i       (w_ser_v),
      .node_id_i (w_entry.is_core ? c_core_id : c_io_id),
      .dnr_i     (w_entry.dnr),
      .len_i     (w_entry.is_core ? c_core_len : c_io_len),
      .payload_i (w_entry.payload),
      .ready_o   (w_ser_ready),
      .last_o    (w_ser_last),
      .data_o    (link_if.tag_data_o)
   );

endmodule
`default_nettype wire

// File: tb/tb_bsg_gateway_chip_io_link_bringup.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bsg_gateway_chip_io_link_bringup                                        |
// | Stream-level bench: expected tag stream built from the packet format rules.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_bsg_gateway_chip_io_link_bringup;

   typedef bit bitq_t[$];

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   bsg_gateway_chip_io_link_bringup_if if_a ();
   bsg_gateway_chip_io_link_bringup_if if_b ();

   bsg_gateway_chip_io_link_bringup dut_a (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .link_if   (if_a)
   );

   bsg_gateway_chip_io_link_bringup #(
      .lg_els_p       (1),
      .lg_width_p     (2),
      .io_node_id_p   (0),
      .core_node_id_p (1),
      .gap_cycles_p   (1)
   ) dut_b (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .link_if   (if_b)
   );

   // Bring-up steps: target client, data_not_reset, payload value (MSB..LSB).
   bit step_core[8] = '{0, 1, 0, 1, 0, 0, 0, 1};
   bit step_dnr [8] = '{0, 0, 1, 1, 1, 1, 1, 1};
   int step_pay [8] = '{7, 3, 7, 3, 6, 2, 0, 0};
   int exp_hist [4] = '{7, 6, 2, 0};

   // Tag client model state (io node 0, core node 1, 4-bit id/len fields).
   bit cl_in_pkt;
   bit cl_hdr[$];
   int cl_io;
   int cl_core;
   int io_hist[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pkt_len(input int s, input int le, input int lw);
      return 2 + le + lw + (step_core[s] ? 2 : 3);
   endfunction

   function automatic bitq_t seq_bits(input int le, input int lw, input int gap,
                                      input int io_id, input int core_id);
      bitq_t q;
      for (int s = 0; s < 8; s++) begin
         int w;
         int id;
         w  = step_core[s] ? 2 : 3;
         id = step_core[s] ? core_id : io_id;
         q.push_back(1'b1);
         for (int b = le - 1; b >= 0; b--) q.push_back(bit'((id >> b) & 1));
         q.push_back(step_dnr[s]);
         for (int b = lw - 1; b >= 0; b--) q.push_back(bit'((w >> b) & 1));
         for (int b = 0; b < w; b++) q.push_back(bit'((step_pay[s] >> b) & 1));
         for (int g = 0; g < gap; g++) q.push_back(1'b0);
      end
      return q;
   endfunction

   task automatic client_bit(input bit b);
      int id, len, pay;
      id = 0; len = 0; pay = 0;
      if (!cl_in_pkt) begin
         if (b) begin
            cl_in_pkt = 1'b1;
            cl_hdr.delete();
         end
      end else begin
         cl_hdr.push_back(b);
         if (cl_hdr.size() >= 9) begin
            for (int i = 0; i < 4; i++) id = id * 2 + int'(cl_hdr[i]);
            for (int i = 5; i < 9; i++) len = len * 2 + int'(cl_hdr[i]);
            if (cl_hdr.size() >= 9 + len) begin
               for (int i = 0; i < len; i++) pay = pay | (int'(cl_hdr[9 + i]) << i);
               cl_in_pkt = 1'b0;
               if (cl_hdr[4]) begin
                  if (id == 0) begin
                     if (pay != cl_io) io_hist.push_back(pay);
                     cl_io = pay;
                  end else if (id == 1) begin
                     cl_core = pay;
                  end
               end
            end
         end
      end
   endtask

   function automatic logic get_tag(input int sel);
      return (sel != 0) ? if_b.tag_data_o : if_a.tag_data_o;
   endfunction
   function automatic logic get_busy(input int sel);
      return (sel != 0) ? if_b.busy_o : if_a.busy_o;
   endfunction
   function automatic logic get_done(input int sel);
      return (sel != 0) ? if_b.done_o : if_a.done_o;
   endfunction

   task automatic set_start(input int sel, input logic v);
      if (sel != 0) if_b.start_i = v;
      else          if_a.start_i = v;
   endtask

   task automatic check_outs(input int sel, input logic t, input logic bz, input logic dn,
                             input string pfx);
      check_eq({pfx, "_tag"},  get_tag(sel),  t);
      check_eq({pfx, "_busy"}, get_busy(sel), bz);
      check_eq({pfx, "_done"}, get_done(sel), dn);
   endtask

   // Full sequence on one DUT; optional spurious start pulses while busy.
   task automatic run_seq(input int sel, input bit spurious, input bit from_done, input string nm);
      bitq_t exp;
      int    idle;
      exp = (sel != 0) ? seq_bits(1, 2, 1, 0, 1) : seq_bits(4, 4, 64, 0, 1);
      if (sel == 0) begin
         cl_in_pkt = 1'b0;
         cl_io     = -1;
         cl_core   = -1;
         io_hist.delete();
      end
      idle = $urandom_range(1, 6);
      for (int i = 0; i < idle; i++) begin
         @(negedge clk);
         check_outs(sel, 1'b0, 1'b0, from_done, $sformatf("%s_pre%0d", nm, i));
      end
      set_start(sel, 1'b1);
      for (int k = 0; k < exp.size(); k++) begin
         @(negedge clk);
         set_start(sel, 1'b0);
         check_outs(sel, exp[k], 1'b1, 1'b0, $sformatf("%s[%0d]", nm, k));
         if (sel == 0) client_bit(get_tag(sel));
         if (spurious && ($urandom_range(0, 15) == 0)) set_start(sel, 1'b1);
      end
      @(negedge clk);
      set_start(sel, 1'b0);
      check_outs(sel, 1'b0, 1'b0, 1'b1, {nm, "_end"});
      if (sel == 0) begin
         check_eq({nm, "_client_io"},   cl_io,   0);
         check_eq({nm, "_client_core"}, cl_core, 0);
         check_eq({nm, "_io_hist_n"},   io_hist.size(), 4);
         for (int i = 0; i < 4; i++)
            check_eq($sformatf("%s_io_hist%0d", nm, i),
                     (i < io_hist.size()) ? io_hist[i] : -1, exp_hist[i]);
      end
   endtask

   // Reset pulse landing on a random bit of the step-5 payload.
   task automatic run_reset();
      bitq_t exp;
      int    r;
      exp = seq_bits(4, 4, 64, 0, 1);
      r = 0;
      for (int s = 0; s < 5; s++) r += pkt_len(s, 4, 4) + 64;
      r += 1 + 4 + 1 + 4 + $urandom_range(0, 2);
      @(negedge clk);
      if_a.start_i = 1'b1;
      for (int k = 0; k < r; k++) begin
         @(negedge clk);
         if_a.start_i = 1'b0;
         check_outs(0, exp[k], 1'b1, 1'b0, $sformatf("rst_run[%0d]", k));
      end
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check_outs(0, 1'b0, 1'b0, 1'b0, "rst_edge");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_outs(0, 1'b0, 1'b0, 1'b0, $sformatf("rst_hold%0d", i));
      end
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_outs(0, 1'b0, 1'b0, 1'b0, $sformatf("rst_after%0d", i));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      if_a.start_i = 1'b0;
      if_b.start_i = 1'b0;
      reset_n      = 1'b0;
      repeat (3) @(negedge clk);
      check_outs(0, 1'b0, 1'b0, 1'b0, "reset_a");
      check_outs(1, 1'b0, 1'b0, 1'b0, "reset_b");
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_outs(0, 1'b0, 1'b0, 1'b0, $sformatf("release%0d", i));
      end
      run_seq(1, 1'b0, 1'b0, "b_seq");
      run_seq(0, 1'b0, 1'b0, "a_seq");
      run_seq(0, 1'b1, 1'b1, "a_restart");
      run_seq(1, 1'b1, 1'b1, "b_restart");
      run_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
